// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl_if
// Purpose  : Bundles the command handshake and the shift datapath signals of
//            shift_seq_ctrl.
//            master : host side. Drives the command fields, en and si.
//            slave  : controller side. Drives cmd_ready, q, so, so_valid,
//                     busy and done.
// Ports    : none (interface signals only)
// Revision : 1.0 - initial release
// ============================================================================
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_dir;
    logic             cmd_rot;
    logic             en;
    logic             si;
    logic [WIDTH-1:0] q;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_data, cmd_count, cmd_dir, cmd_rot, en, si,
        input  cmd_ready, q, so, so_valid, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_count, cmd_dir, cmd_rot, en, si,
        output cmd_ready, q, so, so_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Command-driven sequencer for a WIDTH-bit bidirectional shift
//            register. It accepts one command at a time. The command loads a
//            word, then shifts or rotates it a programmed number of positions
//            in the chosen direction.
// Ports    : clk  - clock. All state changes on the rising edge.
//            rst  - synchronous, active-high reset.
//            bus  - shift_seq_ctrl_if.slave. Command handshake (cmd_*),
//                   shift enable en and serial input si. Register contents q,
//                   serial output so/so_valid, and the busy/done status.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    shift_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_WIDTH_CNT = CNT_W'(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_remaining;
    logic             r_dir;
    logic             r_rot;

    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_so_valid;
    logic             w_busy;
    logic             w_done;
    logic             w_so;
    logic             w_fill;
    logic [CNT_W-1:0] w_count_clamped;

    // A request for more shifts than the register has bits is clamped to WIDTH.
    assign w_count_clamped = (bus.cmd_count > c_WIDTH_CNT) ? c_WIDTH_CNT : bus.cmd_count;

    // This is the bit that leaves the register. In rotate mode it re-enters at the other end.
    assign w_so   = r_dir ? r_q[0] : r_q[WIDTH-1];
    assign w_fill = r_rot ? w_so : bus.si;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        w_so_valid  = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Keep the handshake closed while reset is held, so no command slips in.
                w_cmd_ready = !rst;
                w_accept    = bus.cmd_valid && !rst;
                if (w_accept) begin
                    w_state_nxt = (w_count_clamped == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (bus.en) begin
                    w_so_valid = !rst;
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_rot       <= 1'b0;
        end else if (w_accept) begin
            r_q         <= bus.cmd_data;
            r_remaining <= w_count_clamped;
            r_dir       <= bus.cmd_dir;
            r_rot       <= bus.cmd_rot;
        end else if (w_so_valid) begin
            r_q         <= r_dir ? {w_fill, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], w_fill};
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.q         = r_q;
    assign bus.so        = w_so;
    assign bus.so_valid  = w_so_valid;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq_ctrl
// Purpose  : Self-checking bench for shift_seq_ctrl. It runs a table of command
//            vectors, and a scoreboard queue holds the expected serial output
//            bits. It also runs hand-written reset sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] count;
        logic       dir;
        logic       rot;
        logic       si;
        int         stall_after;   // shifts completed before en drops; -1 = never
        int         stall_len;
        logic [7:0] stall_q;
        logic       hold_valid;    // keep offering a 8'hFF command while busy
        logic [7:0] exp_q;
        int         exp_lat;       // cycle index after accept where done is seen
        int         exp_shifts;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;
    bit so_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] m;
        logic       sob;
        logic       fill;
        int         n;
        int         shifts;
        int         stalled;
        bit         finished;
        // Reference model: predict the serial output bits.
        m = v.data;
        n = (int'(v.count) > WIDTH) ? WIDTH : int'(v.count);
        for (int i = 0; i < n; i++) begin
            sob  = v.dir ? m[0] : m[7];
            so_q.push_back(sob);
            fill = v.rot ? sob : v.si;
            m    = v.dir ? {fill, m[7:1]} : {m[6:0], fill};
        end

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = v.data;
        bus.cmd_count = v.count;
        bus.cmd_dir   = v.dir;
        bus.cmd_rot   = v.rot;
        bus.si        = v.si;
        bus.en        = 1'b1;
        #1 check($sformatf("v%0d_ready_idle", idx), 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);

        shifts   = 0;
        stalled  = 0;
        finished = 0;
        for (int k = 1; k <= 40 && !finished; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // The command fields are sampled only at acceptance, so this change must be ignored.
                bus.cmd_data  = v.hold_valid ? 8'hFF : ~v.data;
                bus.cmd_count = v.count + 4'd3;
                bus.cmd_dir   = ~v.dir;
                bus.cmd_rot   = ~v.rot;
                bus.cmd_valid = v.hold_valid;
            end
            if (shifts == v.stall_after && stalled < v.stall_len) begin
                bus.en = 1'b0;
                stalled++;
            end else begin
                bus.en = 1'b1;
            end
            #1;
            if (v.hold_valid)
                check($sformatf("v%0d_ready_busy", idx), 32'(bus.cmd_ready), 32'd0);
            if (bus.done) begin
                finished = 1;
                check($sformatf("v%0d_latency", idx), 32'(k), 32'(v.exp_lat));
                check($sformatf("v%0d_q_final", idx), 32'(bus.q), 32'(v.exp_q));
                check($sformatf("v%0d_busy_done", idx), 32'(bus.busy), 32'd1);
                check($sformatf("v%0d_sov_done", idx), 32'(bus.so_valid), 32'd0);
                bus.cmd_valid = 1'b0;
            end else begin
                check($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
                if (bus.so_valid) begin
                    if (so_q.size() == 0) begin
                        check($sformatf("v%0d_extra_shift", idx), 32'd1, 32'd0);
                    end else begin
                        sob = so_q.pop_front();
                        check($sformatf("v%0d_so%0d", idx, shifts), 32'(bus.so), 32'(sob));
                    end
                    shifts++;
                end else if (!bus.en) begin
                    check($sformatf("v%0d_q_stall", idx), 32'(bus.q), 32'(v.stall_q));
                end
            end
        end
        if (!finished)
            check($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
        check($sformatf("v%0d_shift_count", idx), 32'(shifts), 32'(v.exp_shifts));
        check($sformatf("v%0d_sb_empty", idx), 32'(so_q.size()), 32'd0);
        so_q.delete();

        @(negedge clk);
        #1;
        check($sformatf("v%0d_ready_after", idx), 32'(bus.cmd_ready), 32'd1);
        check($sformatf("v%0d_done_once", idx), 32'(bus.done), 32'd0);
        check($sformatf("v%0d_busy_after", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d_q_hold", idx), 32'(bus.q), 32'(v.exp_q));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            data   cnt dir rot si stA stL stq    hold expq   lat shifts
        vecs[0] = '{8'hA5, 4'd3,  1'b0, 1'b0, 1'b1, -1, 0, 8'h00, 1'b0, 8'h2F, 4, 3};
        vecs[1] = '{8'h81, 4'd1,  1'b1, 1'b1, 1'b0, -1, 0, 8'h00, 1'b0, 8'hC0, 2, 1};
        vecs[2] = '{8'h3C, 4'd0,  1'b0, 1'b0, 1'b1, -1, 0, 8'h00, 1'b0, 8'h3C, 1, 0};
        vecs[3] = '{8'hFF, 4'd12, 1'b1, 1'b0, 1'b0, -1, 0, 8'h00, 1'b0, 8'h00, 9, 8};
        vecs[4] = '{8'h01, 4'd4,  1'b0, 1'b0, 1'b0,  1, 2, 8'h02, 1'b0, 8'h10, 7, 4};
        vecs[5] = '{8'h96, 4'd2,  1'b1, 1'b1, 1'b0, -1, 0, 8'h00, 1'b1, 8'hA5, 3, 2};
        vecs[6] = '{8'h3C, 4'd8,  1'b0, 1'b1, 1'b0, -1, 0, 8'h00, 1'b0, 8'h3C, 9, 8};

        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_count = '0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_rot   = 1'b0;
        bus.en        = 1'b1;
        bus.si        = 1'b0;

        // Reset state, with a command offered while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h77;
        bus.cmd_count = 4'd2;
        #1;
        check("rst_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_so_valid", 32'(bus.so_valid), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        #1 check("rst_release_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < NVEC; i++)
            run_vec(vecs[i], i);

        // Assert reset in the middle of a shift sequence, after two shifts.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hA5;
        bus.cmd_count = 4'd5;
        bus.cmd_dir   = 1'b0;
        bus.cmd_rot   = 1'b0;
        bus.si        = 1'b1;
        bus.en        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1 check("mid_sov1", 32'(bus.so_valid), 32'd1);
        @(negedge clk);
        #1 check("mid_sov2", 32'(bus.so_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_q_partial", 32'(bus.q), 32'h97);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
        check("mid_rst_sov", 32'(bus.so_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_q_cleared", 32'(bus.q), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_done", 32'(bus.done), 32'd0);
        check("mid_ready", 32'(bus.cmd_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1 check($sformatf("mid_no_done%0d", k), 32'(bus.done), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
